// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for a syn_fifo with a registered read port.
// Pops a requested number of words and streams them out over valid/ready,
// with m_last on the final word. A 2-entry skid buffer absorbs the one-cycle
// FIFO read latency so backpressure never drops a word.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; burst_len sampled here
// S_RUN  | issuing pops and streaming words until the last is accepted
// S_DONE | one-cycle completion pulse, then back to S_IDLE

module fifo_burst_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
  logic [LEN_WIDTH-1:0]  out_left_q, out_left_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic                  accept;
  logic                  pop_en;
  logic                  tail_is_head;
  logic [2:0]            occupancy;

  // Next-state, counters, buffer update and pop decision.
  always_comb begin
    state_d      = state_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    inflight_d   = 1'b0;

    accept = (buf_cnt_q != 2'd0) & m_ready;
    // Words already owned after this cycle: buffered plus in flight, minus the one leaving.
    occupancy = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, accept};
    pop_en = (state_q == S_RUN) & ~fifo_empty & (issue_left_q != LEN_ZERO) &
             (occupancy < 3'd2);
    buf_cnt_d = occupancy[1:0];

    // The arriving word lands in the head slot if the buffer is empty after the pop-out.
    tail_is_head = (buf_cnt_q == 2'd0) | ((buf_cnt_q == 2'd1) & accept);

    if (accept) begin
      buf0_d     = buf1_q;
      out_left_d = out_left_q - LEN_ONE;
    end
    if (inflight_q) begin
      if (tail_is_head) begin
        buf0_d = fifo_data;
      end else begin
        buf1_d = fifo_data;
      end
    end

    if (pop_en) begin
      issue_left_d = issue_left_q - LEN_ONE;
      inflight_d   = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (burst_len != LEN_ZERO) begin
            issue_left_d = burst_len;
            out_left_d   = burst_len;
            state_d      = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (accept && (out_left_q == LEN_ONE)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards buffered and in-flight words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      issue_left_q <= '0;
      out_left_q   <= '0;
      buf_cnt_q    <= 2'd0;
      inflight_q   <= 1'b0;
      buf0_q       <= '0;
      buf1_q       <= '0;
    end else begin
      state_q      <= state_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      buf_cnt_q    <= buf_cnt_d;
      inflight_q   <= inflight_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
    end
  end

  // Output decode.
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    fifo_rd_en = pop_en;
    fifo_rd_cs = pop_en;
    m_valid    = (buf_cnt_q != 2'd0);
    m_data     = buf0_q;
    m_last     = m_valid & (out_left_q == LEN_ONE);
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO with one-cycle read latency,
// and a transaction-level reference of the burst (phase, pops, accepted words).
`timescale 1ns/1ps

module tb_fifo_burst_reader;

  localparam int DW = 64;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          busy, done;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_cs, fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_cs(fifo_rd_cs), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  // reference model of the burst
  int phase;            // 0 idle, 1 running, 2 completion cycle
  int blen, pops, accs, cyc;
  int first_pop, first_valid, first_acc, last_acc, valid_cnt;
  bit gap_seen, stall_prev, prev_last;
  logic [DW-1:0] prev_data;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase = 0; blen = 0; pops = 0; accs = 0;
    first_pop = -1; first_valid = -1; first_acc = -1; last_acc = -1;
    valid_cnt = 0; gap_seen = 0; stall_prev = 0; prev_last = 0; prev_data = '0;
  endtask

  task automatic monitor();
    bit acc;
    logic [DW-1:0] w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = m_valid & m_ready;
    check_eq("busy", busy, (phase != 0));
    check_eq("done", done, (phase == 2));
    check_eq("rd_cs", fifo_rd_cs, fifo_rd_en);
    if (phase != 1) begin
      check_eq("idle_rd_en", fifo_rd_en, 1'b0);
      check_eq("idle_valid", m_valid, 1'b0);
    end
    if (fifo_rd_en) begin
      check_eq("pop_nonempty", fifo_empty, 1'b0);
      check_eq("pop_limit", (pops < blen), 1'b1);
      check_eq("pop_room", ((pops - accs - int'(acc)) < 2), 1'b1);
      if (first_pop < 0) first_pop = cyc;
    end
    if (stall_prev) begin
      check_eq("hold_valid", m_valid, 1'b1);
      check_eq("hold_data", m_data, prev_data);
      check_eq("hold_last", m_last, prev_last);
    end
    if (m_valid) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
      check_eq("last", m_last, (accs == blen - 1));
    end else begin
      check_eq("last_novalid", m_last, 1'b0);
      if (phase == 1 && first_valid >= 0 && accs < blen) gap_seen = 1;
    end
    if (acc) begin
      if (exp_q.size() == 0) begin
        check_eq("data_extra", 1'b1, 1'b0);
      end else begin
        w = exp_q.pop_front();
        check_eq("data", m_data, w);
      end
      accs++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    stall_prev = m_valid & ~m_ready;
    prev_data = m_data;
    prev_last = m_last;
    if (fifo_rd_en) pops++;
    case (phase)
      0: if (start) begin
           blen = int'(burst_len); pops = 0; accs = 0; valid_cnt = 0; gap_seen = 0;
           first_pop = -1; first_valid = -1; first_acc = -1; last_acc = -1;
           phase = (burst_len == 0) ? 2 : 1;
         end
      1: if (acc && accs == blen) phase = 2;
      default: phase = 0;
    endcase
    cyc++;
  endtask

  // One clock: check at the falling edge, then emulate the FIFO read port.
  task automatic tick();
    bit rd;
    @(negedge clk);
    monitor();
    rd = fifo_rd_en & rst_n;
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    start = 1'b0;
  endtask

  task automatic push_words(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic flush();
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0: return 1'b1;
      1: return (k % 3 == 0);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // mode: 0 always ready, 1 pattern 1,0,0, 2 random
  task automatic run_burst(input int len, input int mode, input int late_n, input int late_at,
                           input int budget);
    start = 1'b1;
    burst_len = LW'(len);
    m_ready = ready_for(mode, 0);
    tick();
    for (int k = 1; k < budget && phase != 0; k++) begin
      m_ready = ready_for(mode, k);
      if (k == late_at) push_words(late_n);
      tick();
    end
    check_eq("timeout", phase, 0);
  endtask

  initial begin
    int len, fill;
    model_reset();
    cyc = 0;
    #23;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_rd_en", fifo_rd_en, 1'b0);
    check_eq("rst_valid", m_valid, 1'b0);
    check_eq("rst_data", m_data, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tick();

    // 1: len 4, four words, always ready
    push_words(4);
    run_burst(4, 0, 0, -1, 40);
    check_eq("t1_pops", pops, 4);
    check_eq("t1_latency", first_valid - first_pop, 2);
    check_eq("t1_back2back", last_acc - first_acc, 3);
    tick();
    flush();

    // 2: len 3 from eight words
    push_words(8);
    run_burst(3, 0, 0, -1, 40);
    check_eq("t2_pops", pops, 3);
    check_eq("t2_fifo_left", fifo_q.size(), 5);
    flush();

    // 3: len 6, ready pattern 1,0,0
    push_words(8);
    run_burst(6, 1, 0, -1, 80);
    check_eq("t3_count", accs, 6);
    flush();

    // 4: FIFO runs dry after two words, three more arrive later
    push_words(2);
    run_burst(5, 0, 3, 10, 80);
    check_eq("t4_count", accs, 5);
    check_eq("t4_gap", gap_seen, 1'b1);
    flush();

    // 5: zero-length burst
    push_words(3);
    run_burst(0, 0, 0, -1, 10);
    check_eq("t5_pops", pops, 0);
    check_eq("t5_valid", valid_cnt, 0);
    flush();

    // 6: reset with one word buffered and one in flight
    push_words(8);
    start = 1'b1; burst_len = LW'(8); m_ready = 1'b0;
    tick();
    tick();
    tick();
    check_eq("t6_pre_valid", m_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_done", done, 1'b0);
    check_eq("t6_rd_en", fifo_rd_en, 1'b0);
    check_eq("t6_rd_cs", fifo_rd_cs, 1'b0);
    check_eq("t6_valid", m_valid, 1'b0);
    check_eq("t6_last", m_last, 1'b0);
    check_eq("t6_data", m_data, '0);
    model_reset();
    tick();
    #2;
    rst_n = 1'b1;
    flush();
    tick();
    push_words(2);
    run_burst(2, 0, 0, -1, 30);
    check_eq("t6_after", accs, 2);
    flush();

    // randomized bursts with late refills and random backpressure
    for (int r = 0; r < 10; r++) begin
      len = $urandom_range(1, 10);
      fill = $urandom_range(0, len);
      push_words(fill);
      run_burst(len, 2, len - fill + $urandom_range(0, 2), $urandom_range(1, 15), 300);
      check_eq("rnd_count", accs, len);
      flush();
    end

    // long burst
    push_words(300);
    run_burst(300, 2, 0, -1, 2000);
    check_eq("long_count", accs, 300);
    flush();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
